// File: rtl/ups_axi4l_regs.sv
// AXI4-Lite register block: control/period/width/trigger registers, a sampled
// status word and a read-only version word. Write and read channels run independently.
module ups_axi4l_regs #(
  parameter logic [31:0] VERSION = 32'h0001_0000
) (
  input  logic        fclk,
  input  logic        rst_n,
  input  logic [31:0] ca4l_awaddr,
  input  logic [2:0]  ca4l_awprot,
  input  logic        ca4l_awvalid,
  output logic        ca4l_awready,
  input  logic [31:0] ca4l_wdata,
  input  logic [3:0]  ca4l_wstrb,
  input  logic        ca4l_wvalid,
  output logic        ca4l_wready,
  output logic [1:0]  ca4l_bresp,
  output logic        ca4l_bvalid,
  input  logic        ca4l_bready,
  input  logic [31:0] ca4l_araddr,
  input  logic [2:0]  ca4l_arprot,
  input  logic        ca4l_arvalid,
  output logic        ca4l_arready,
  output logic [31:0] ca4l_rdata,
  output logic [1:0]  ca4l_rresp,
  output logic        ca4l_rvalid,
  input  logic        ca4l_rready,
  output logic [3:0]  ctrl,
  output logic [31:0] period,
  output logic [31:0] width,
  output logic        trig,
  output logic        trig_pulse,
  input  logic [31:0] status
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [5:0] OFF_CTRL    = 6'h00;
  localparam logic [5:0] OFF_PERIOD  = 6'h01;
  localparam logic [5:0] OFF_WIDTH   = 6'h02;
  localparam logic [5:0] OFF_TRIG    = 6'h03;
  localparam logic [5:0] OFF_STATUS  = 6'h04;
  localparam logic [5:0] OFF_VERSION = 6'h05;

  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] nxt,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = nxt[8*b +: 8];
    end
    return res;
  endfunction

  logic        aw_held;
  logic [5:0]  aw_off;
  logic        w_held;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        bvalid_q;
  logic [1:0]  bresp_q;

  logic [3:0]  ctrl_q;
  logic [31:0] period_q;
  logic [31:0] width_q;
  logic        trig_q;
  logic        trig_d;
  logic        pulse_q;
  logic [31:0] status_q;

  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;

  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic commit;
  logic unused_inputs;

  // Only addr[7:2] selects a register; the rest of the address and prot are don't-care.
  assign unused_inputs = ^{ca4l_awaddr[31:8], ca4l_awaddr[1:0], ca4l_awprot,
                           ca4l_araddr[31:8], ca4l_araddr[1:0], ca4l_arprot};

  assign ca4l_awready = rst_n & ~aw_held & ~bvalid_q;
  assign ca4l_wready  = rst_n & ~w_held  & ~bvalid_q;
  assign ca4l_arready = rst_n & ~rvalid_q;

  assign aw_hs  = ca4l_awvalid & ca4l_awready;
  assign w_hs   = ca4l_wvalid  & ca4l_wready;
  assign ar_hs  = ca4l_arvalid & ca4l_arready;
  // Holds are only accepted while bvalid is low, so both held implies no response pending.
  assign commit = aw_held & w_held;

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held  <= 1'b0;
      aw_off   <= '0;
      w_held   <= 1'b0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_off  <= ca4l_awaddr[7:2];
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= ca4l_wdata;
        w_strb <= ca4l_wstrb;
      end
      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= (aw_off <= OFF_TRIG) ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q && ca4l_bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q   <= '0;
      period_q <= '0;
      width_q  <= '0;
      trig_q   <= 1'b0;
      trig_d   <= 1'b0;
      pulse_q  <= 1'b0;
      status_q <= '0;
    end else begin
      status_q <= status;
      trig_d   <= trig_q;
      pulse_q  <= trig_q & ~trig_d;
      if (commit) begin
        case (aw_off)
          OFF_CTRL:   if (w_strb[0]) ctrl_q <= w_data[3:0];
          OFF_PERIOD: period_q <= byte_merge(period_q, w_data, w_strb);
          OFF_WIDTH:  width_q  <= byte_merge(width_q, w_data, w_strb);
          OFF_TRIG:   if (w_strb[0]) trig_q <= w_data[0];
          default:    ;
        endcase
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (ca4l_araddr[7:2])
      OFF_CTRL:    rd_data = {28'd0, ctrl_q};
      OFF_PERIOD:  rd_data = period_q;
      OFF_WIDTH:   rd_data = width_q;
      OFF_TRIG:    rd_data = {31'd0, trig_q};
      OFF_STATUS:  rd_data = status_q;
      OFF_VERSION: rd_data = VERSION;
      default:     rd_resp = RESP_SLVERR;
    endcase
  end

  // Read captures register state before any write committing on the same edge.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data;
      rresp_q  <= rd_resp;
    end else if (rvalid_q && ca4l_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign ca4l_bvalid = bvalid_q;
  assign ca4l_bresp  = bresp_q;
  assign ca4l_rvalid = rvalid_q;
  assign ca4l_rdata  = rdata_q;
  assign ca4l_rresp  = rresp_q;
  assign ctrl        = ctrl_q;
  assign period      = period_q;
  assign width       = width_q;
  assign trig        = trig_q;
  assign trig_pulse  = pulse_q;

endmodule

// File: tb/tb_ups_axi4l_regs.sv
// Bench for ups_axi4l_regs: directed scenarios plus randomized traffic checked
// against a register-map model held in plain arrays.
module tb_ups_axi4l_regs;

  localparam logic [31:0] VER = 32'h0001_0000;

  logic        fclk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] ca4l_awaddr = '0;
  logic [2:0]  ca4l_awprot = '0;
  logic        ca4l_awvalid = 1'b0;
  logic        ca4l_awready;
  logic [31:0] ca4l_wdata = '0;
  logic [3:0]  ca4l_wstrb = '0;
  logic        ca4l_wvalid = 1'b0;
  logic        ca4l_wready;
  logic [1:0]  ca4l_bresp;
  logic        ca4l_bvalid;
  logic        ca4l_bready = 1'b0;
  logic [31:0] ca4l_araddr = '0;
  logic [2:0]  ca4l_arprot = '0;
  logic        ca4l_arvalid = 1'b0;
  logic        ca4l_arready;
  logic [31:0] ca4l_rdata;
  logic [1:0]  ca4l_rresp;
  logic        ca4l_rvalid;
  logic        ca4l_rready = 1'b0;
  logic [3:0]  ctrl;
  logic [31:0] period;
  logic [31:0] width;
  logic        trig;
  logic        trig_pulse;
  logic [31:0] status = '0;

  always #5 fclk = ~fclk;

  ups_axi4l_regs #(.VERSION(VER)) dut (
    .fclk(fclk), .rst_n(rst_n),
    .ca4l_awaddr(ca4l_awaddr), .ca4l_awprot(ca4l_awprot),
    .ca4l_awvalid(ca4l_awvalid), .ca4l_awready(ca4l_awready),
    .ca4l_wdata(ca4l_wdata), .ca4l_wstrb(ca4l_wstrb),
    .ca4l_wvalid(ca4l_wvalid), .ca4l_wready(ca4l_wready),
    .ca4l_bresp(ca4l_bresp), .ca4l_bvalid(ca4l_bvalid), .ca4l_bready(ca4l_bready),
    .ca4l_araddr(ca4l_araddr), .ca4l_arprot(ca4l_arprot),
    .ca4l_arvalid(ca4l_arvalid), .ca4l_arready(ca4l_arready),
    .ca4l_rdata(ca4l_rdata), .ca4l_rresp(ca4l_rresp),
    .ca4l_rvalid(ca4l_rvalid), .ca4l_rready(ca4l_rready),
    .ctrl(ctrl), .period(period), .width(width), .trig(trig),
    .trig_pulse(trig_pulse), .status(status)
  );

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  bit mon_en = 1'b0;
  logic h1 = 1'b0;
  logic h2 = 1'b0;
  logic [31:0] m_reg [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference register map: byte-strobed RW words, masked to implemented bits.
  function automatic logic [31:0] rw_mask(input int off);
    case (off)
      0:       return 32'h0000_000F;
      3:       return 32'h0000_0001;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [1:0] m_write(input logic [31:0] addr, input logic [31:0] data,
                                         input logic [3:0] strb);
    int off;
    logic [31:0] v;
    off = int'(addr[7:2]);
    if (off > 3) return 2'b10;
    v = m_reg[off];
    for (int b = 0; b < 4; b++)
      if (strb[b]) v[8*b +: 8] = data[8*b +: 8];
    m_reg[off] = v & rw_mask(off);
    return 2'b00;
  endfunction

  function automatic void m_read(input logic [31:0] addr, output logic [31:0] d,
                                 output logic [1:0] r);
    int off;
    off = int'(addr[7:2]);
    r = 2'b00;
    if (off <= 3)      d = m_reg[off];
    else if (off == 4) d = status;
    else if (off == 5) d = VER;
    else begin
      d = '0;
      r = 2'b10;
    end
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = '0;
  endfunction

  // Pulse rule: trig_pulse is high exactly in the cycle after trig was first seen high.
  always @(negedge fclk) begin
    if (mon_en) begin
      if (!rst_n) begin
        chk("pulse_in_reset", 32'(trig_pulse), 32'd0);
        h1 = 1'b0;
        h2 = 1'b0;
      end else begin
        chk("trig_pulse", 32'(trig_pulse), 32'(h1 & ~h2));
        if (trig_pulse) pulse_cnt++;
        h2 = h1;
        h1 = trig;
      end
    end
  end

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_dly, output logic [1:0] resp);
    int n;
    fork
      begin : aw_ph
        int k;
        repeat (aw_dly) @(posedge fclk);
        if (aw_dly > 0) #1;
        ca4l_awaddr = addr;
        ca4l_awprot = 3'($urandom);
        ca4l_awvalid = 1'b1;
        k = 0;
        while (!ca4l_awready && k < 40) begin
          @(posedge fclk); #1; k++;
        end
        chk("awready", 32'(ca4l_awready), 32'd1);
        @(posedge fclk); #1;
        ca4l_awvalid = 1'b0;
      end
      begin : w_ph
        int k;
        repeat (w_dly) @(posedge fclk);
        if (w_dly > 0) #1;
        ca4l_wdata = data;
        ca4l_wstrb = strb;
        ca4l_wvalid = 1'b1;
        k = 0;
        while (!ca4l_wready && k < 40) begin
          @(posedge fclk); #1; k++;
        end
        chk("wready", 32'(ca4l_wready), 32'd1);
        @(posedge fclk); #1;
        ca4l_wvalid = 1'b0;
      end
    join
    n = 0;
    while (!ca4l_bvalid && n < 40) begin
      @(posedge fclk); #1; n++;
    end
    chk("bvalid", 32'(ca4l_bvalid), 32'd1);
    resp = ca4l_bresp;
    repeat (b_dly) begin
      @(posedge fclk); #1;
      chk("bvalid_hold", 32'(ca4l_bvalid), 32'd1);
      chk("bresp_hold", 32'(ca4l_bresp), 32'(resp));
      chk("awready_blocked", 32'(ca4l_awready), 32'd0);
    end
    ca4l_bready = 1'b1;
    @(posedge fclk); #1;
    ca4l_bready = 1'b0;
    chk("bvalid_clear", 32'(ca4l_bvalid), 32'd0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp);
    int k;
    repeat (ar_dly) @(posedge fclk);
    if (ar_dly > 0) #1;
    ca4l_araddr = addr;
    ca4l_arprot = 3'($urandom);
    ca4l_arvalid = 1'b1;
    k = 0;
    while (!ca4l_arready && k < 40) begin
      @(posedge fclk); #1; k++;
    end
    chk("arready", 32'(ca4l_arready), 32'd1);
    @(posedge fclk); #1;
    ca4l_arvalid = 1'b0;
    chk("rvalid", 32'(ca4l_rvalid), 32'd1);
    data = ca4l_rdata;
    resp = ca4l_rresp;
    repeat (r_dly) begin
      @(posedge fclk); #1;
      chk("rvalid_hold", 32'(ca4l_rvalid), 32'd1);
      chk("rdata_hold", ca4l_rdata, data);
      chk("arready_blocked", 32'(ca4l_arready), 32'd0);
    end
    ca4l_rready = 1'b1;
    @(posedge fclk); #1;
    ca4l_rready = 1'b0;
    chk("rvalid_clear", 32'(ca4l_rvalid), 32'd0);
  endtask

  task automatic check_ports(input string tag);
    chk({tag, "_ctrl"},   32'(ctrl),  m_reg[0]);
    chk({tag, "_period"}, period,     m_reg[1]);
    chk({tag, "_width"},  width,      m_reg[2]);
    chk({tag, "_trig"},   32'(trig),  m_reg[3]);
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input int aw_dly, input int w_dly, input int b_dly);
    logic [1:0] r;
    logic [1:0] e;
    axi_write(addr, data, strb, aw_dly, w_dly, b_dly, r);
    e = m_write(addr, data, strb);
    chk({tag, "_bresp"}, 32'(r), 32'(e));
    check_ports(tag);
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input int ar_dly, input int r_dly);
    logic [31:0] d;
    logic [31:0] ed;
    logic [1:0]  r;
    logic [1:0]  er;
    axi_read(addr, ar_dly, r_dly, d, r);
    m_read(addr, ed, er);
    chk({tag, "_rdata"}, d, ed);
    chk({tag, "_rresp"}, 32'(r), 32'(er));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] ed;
    logic [1:0]  r;
    logic [1:0]  rr;
    logic [1:0]  er;
    logic [5:0]  off6;
    logic [31:0] addr;

    m_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge fclk);
    #1;
    chk("rst_awready", 32'(ca4l_awready), 32'd0);
    chk("rst_wready",  32'(ca4l_wready),  32'd0);
    chk("rst_arready", 32'(ca4l_arready), 32'd0);
    chk("rst_bvalid",  32'(ca4l_bvalid),  32'd0);
    chk("rst_rvalid",  32'(ca4l_rvalid),  32'd0);
    chk("rst_pulse",   32'(trig_pulse),   32'd0);
    check_ports("rst");
    rst_n = 1'b1;
    #1;
    chk("rel_awready", 32'(ca4l_awready), 32'd1);
    chk("rel_wready",  32'(ca4l_wready),  32'd1);
    chk("rel_arready", 32'(ca4l_arready), 32'd1);
    mon_en = 1'b1;

    // AW leads W by one cycle
    wr("period_444", 32'h04, 32'h0000_0444, 4'hF, 0, 1, 0);
    chk("period_444_port", period, 32'h0000_0444);
    rd("period_444_rd", 32'h04, 0, 0);

    // W two cycles ahead of AW, response stalled 5 cycles
    wr("width_222", 32'h08, 32'h0000_0222, 4'hF, 2, 0, 5);
    chk("width_222_port", width, 32'h0000_0222);

    pulse_cnt = 0;
    wr("trig1a", 32'h0C, 32'h1, 4'hF, 0, 0, 0);
    chk("trig1a_val", 32'(trig), 32'd1);
    wr("trig1b", 32'h0C, 32'h1, 4'hF, 1, 0, 0);
    chk("trig1b_val", 32'(trig), 32'd1);
    wr("trig0", 32'h0C, 32'h0, 4'hF, 0, 1, 0);
    chk("trig0_val", 32'(trig), 32'd0);
    repeat (4) @(posedge fclk);
    #1;
    chk("trig_pulse_count", 32'(pulse_cnt), 32'd1);

    wr("period_zero", 32'h04, 32'h0, 4'hF, 0, 0, 0);
    wr("period_strb", 32'h04, 32'hFFFF_FFFF, 4'b0101, 0, 0, 0);
    chk("period_strb_port", period, 32'h00FF_00FF);

    wr("ro_write", 32'h14, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    rd("unmapped_rd", 32'h20, 0, 0);
    axi_read(32'h14, 0, 2, d, r);
    chk("version_rd", d, 32'h0001_0000);
    chk("version_rresp", 32'(r), 32'd0);

    status = 32'hC0FF_EE01;
    repeat (2) @(posedge fclk);
    #1;
    rd("status_rd", 32'h10, 0, 1);

    // Read and write to the same register completing on the same edge
    wr("pre_same", 32'h08, 32'hA5A5_0001, 4'hF, 0, 0, 0);
    fork
      axi_write(32'h08, 32'h5A5A_0002, 4'hF, 0, 0, 0, r);
      axi_read(32'h08, 1, 0, d, rr);
    join
    chk("same_edge_rdata", d, 32'hA5A5_0001);
    chk("same_edge_bresp", 32'(r), 32'(m_write(32'h08, 32'h5A5A_0002, 4'hF)));
    check_ports("same_edge");

    // Held address waits for late data while a read completes
    m_read(32'h04, ed, er);
    fork
      axi_write(32'h100, 32'h0000_0009, 4'hF, 0, 15, 0, r);
      begin
        axi_read(32'h04, 3, 1, d, rr);
        chk("indep_rdata", d, ed);
        chk("indep_awheld", 32'(ca4l_awready), 32'd0);
        chk("indep_no_bvalid", 32'(ca4l_bvalid), 32'd0);
      end
    join
    chk("indep_bresp", 32'(r), 32'(m_write(32'h100, 32'h0000_0009, 4'hF)));
    check_ports("indep");

    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        status = $urandom;
        repeat (2) @(posedge fclk);
        #1;
      end
      off6 = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(6, 63)) : 6'($urandom_range(0, 5));
      addr = {24'($urandom), off6, 2'($urandom)};
      if ($urandom_range(0, 1) == 1)
        wr("rnd_wr", addr, $urandom, 4'($urandom), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      else
        rd("rnd_rd", addr, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Reset while a write response is pending
    ca4l_awaddr = 32'h0;
    ca4l_wdata = 32'h2;
    ca4l_wstrb = 4'hF;
    ca4l_awvalid = 1'b1;
    ca4l_wvalid = 1'b1;
    @(posedge fclk); #1;
    ca4l_awvalid = 1'b0;
    ca4l_wvalid = 1'b0;
    for (int k = 0; k < 40 && !ca4l_bvalid; k++) begin
      @(posedge fclk); #1;
    end
    chk("prerst_bvalid", 32'(ca4l_bvalid), 32'd1);
    chk("prerst_ctrl", 32'(ctrl), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_bvalid", 32'(ca4l_bvalid), 32'd0);
    chk("midrst_ctrl", 32'(ctrl), 32'd0);
    chk("midrst_awready", 32'(ca4l_awready), 32'd0);
    m_reset();
    repeat (2) @(posedge fclk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("postrst_awready", 32'(ca4l_awready), 32'd1);
    chk("postrst_wready",  32'(ca4l_wready),  32'd1);
    chk("postrst_arready", 32'(ca4l_arready), 32'd1);
    ca4l_bready = 1'b1;
    repeat (5) begin
      @(posedge fclk); #1;
      chk("postrst_no_bvalid", 32'(ca4l_bvalid), 32'd0);
    end
    ca4l_bready = 1'b0;
    check_ports("postrst");
    rd("postrst_ctrl_rd", 32'h00, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
